// File: rtl/wb_regfile_if.sv
// Bundle of MEM/WB write-back fields and decode read-port signals for wb_regfile.
// The master drives the pipeline fields and read indices; the slave returns data.
interface wb_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             wb_rw;
    logic             wb_md;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_g;
    logic [XLEN-1:0]  wb_data;
    logic [6:0]       wb_opcode;
    logic [2:0]       wb_funct3;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  wb_result;
    logic             wb_we;
    logic [CNT_W-1:0] instret;

    modport master (
        output wb_rw, wb_md, wb_rd, wb_g, wb_data, wb_opcode, wb_funct3,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_result, wb_we, instret
    );

    modport slave (
        input  wb_rw, wb_md, wb_rd, wb_g, wb_data, wb_opcode, wb_funct3,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_result, wb_we, instret
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects ALU or extracted load result, writes the integer
// register file, serves two bypassed decode read ports and counts retirements.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  load_val;
    logic [XLEN-1:0]  result;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic             we;

    always_comb begin
        sel_byte = '0;
        sel_half = '0;
        unique case (bus.wb_g[1:0])
            2'd0: sel_byte = bus.wb_data[7:0];
            2'd1: sel_byte = bus.wb_data[15:8];
            2'd2: sel_byte = bus.wb_data[23:16];
            2'd3: sel_byte = bus.wb_data[31:24];
        endcase
        sel_half = bus.wb_g[1] ? bus.wb_data[31:16] : bus.wb_data[15:0];
    end

    always_comb begin
        load_val = bus.wb_data;
        case (bus.wb_funct3)
            3'b000:  load_val = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, sel_byte};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, sel_half};
            default: load_val = bus.wb_data;
        endcase
    end

    assign result = bus.wb_md ? load_val : bus.wb_g;
    assign we     = bus.wb_rw && (bus.wb_rd != 5'd0);

    assign bus.wb_result = result;
    assign bus.wb_we     = we;
    assign bus.instret   = instret_q;

    // we already excludes x0, so a zero index can only come from storage path
    always_comb begin
        if (bus.rs1_addr == 5'd0)
            bus.rs1_data = '0;
        else if (we && bus.rs1_addr == bus.wb_rd)
            bus.rs1_data = result;
        else
            bus.rs1_data = regs[bus.rs1_addr];

        if (bus.rs2_addr == 5'd0)
            bus.rs2_data = '0;
        else if (we && bus.rs2_addr == bus.wb_rd)
            bus.rs2_data = result;
        else
            bus.rs2_data = regs[bus.rs2_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[bus.wb_rd] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            instret_q <= '0;
        else if (bus.wb_opcode != 7'h00)
            instret_q <= instret_q + 1'b1;
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, load extraction, x0,
// bypass, retirement counting and counter wrap.
module tb_wb_regfile;
    logic clk;
    logic reset;
    int   tests;
    int   failures;

    wb_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();

    wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_rw     = 1'b0;
        bus.wb_md     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_g      = '0;
        bus.wb_data   = '0;
        bus.wb_opcode = 7'h00;
        bus.wb_funct3 = 3'b000;
        bus.rs1_addr  = 5'd0;
        bus.rs2_addr  = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd31;
        #1;
        tests++;
        if (bus.instret !== 64'd0) begin
            failures++;
            $display("FAIL reset_instret: got %0h expected 0", bus.instret);
        end
        tests++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: got %h/%h expected 0/0", bus.rs1_data, bus.rs2_data);
        end
        tests++;
        if (bus.wb_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_we: got %b expected 0", bus.wb_we);
        end
    endtask

    task automatic test_write_reset();
        idle();
        bus.wb_rw = 1'b1; bus.wb_rd = 5'd5; bus.wb_g = 32'h1234; bus.wb_opcode = 7'h33;
        step();
        bus.wb_rw = 1'b0; bus.wb_opcode = 7'h00; bus.rs1_addr = 5'd5;
        #1;
        tests++;
        if (bus.rs1_data !== 32'h1234) begin
            failures++;
            $display("FAIL write_x5: got %h expected 00001234", bus.rs1_data);
        end
        tests++;
        if (bus.instret !== 64'd1) begin
            failures++;
            $display("FAIL write_instret: got %0d expected 1", bus.instret);
        end
        bus.wb_rw = 1'b1; bus.wb_rd = 5'd6; bus.wb_g = 32'h9999; bus.wb_opcode = 7'h33;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
        #1;
        tests++;
        if (bus.rs1_data !== 32'd0) begin
            failures++;
            $display("FAIL midreset_x5: got %h expected 00000000", bus.rs1_data);
        end
        tests++;
        if (bus.rs2_data !== 32'd0) begin
            failures++;
            $display("FAIL midreset_lost_write: got %h expected 00000000", bus.rs2_data);
        end
        tests++;
        if (bus.instret !== 64'd0) begin
            failures++;
            $display("FAIL midreset_instret: got %0d expected 0", bus.instret);
        end
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3  [10];
        logic [1:0]  off [10];
        logic        md  [10];
        logic [31:0] exp [10];
        f3[0] = 3'b000; off[0] = 2'd2; md[0] = 1'b1; exp[0] = 32'hFFFFFFFF;
        f3[1] = 3'b100; off[1] = 2'd3; md[1] = 1'b1; exp[1] = 32'h00000080;
        f3[2] = 3'b001; off[2] = 2'd2; md[2] = 1'b1; exp[2] = 32'hFFFF80FF;
        f3[3] = 3'b101; off[3] = 2'd0; md[3] = 1'b1; exp[3] = 32'h00007F01;
        f3[4] = 3'b010; off[4] = 2'd3; md[4] = 1'b1; exp[4] = 32'h80FF7F01;
        f3[5] = 3'b011; off[5] = 2'd1; md[5] = 1'b1; exp[5] = 32'h80FF7F01;
        f3[6] = 3'b000; off[6] = 2'd0; md[6] = 1'b1; exp[6] = 32'h00000001;
        f3[7] = 3'b001; off[7] = 2'd3; md[7] = 1'b1; exp[7] = 32'hFFFF80FF;
        f3[8] = 3'b101; off[8] = 2'd1; md[8] = 1'b1; exp[8] = 32'h00007F01;
        f3[9] = 3'b000; off[9] = 2'd2; md[9] = 1'b0; exp[9] = 32'h12345672;
        idle();
        bus.wb_data = 32'h80FF7F01;
        for (int i = 0; i < 10; i++) begin
            bus.wb_md     = md[i];
            bus.wb_funct3 = f3[i];
            bus.wb_g      = md[i] ? {30'h0000_1000, off[i]} : 32'h12345672;
            #1;
            tests++;
            if (bus.wb_result !== exp[i]) begin
                failures++;
                $display("FAIL load_extract[%0d] f3=%b off=%0d: got %h expected %h",
                         i, f3[i], off[i], bus.wb_result, exp[i]);
            end
        end
        bus.wb_md = 1'b1; bus.wb_funct3 = 3'b000; bus.wb_g = 32'h1001;
        bus.wb_rw = 1'b1; bus.wb_rd = 5'd9; bus.wb_opcode = 7'h03;
        step();
        idle();
        bus.rs2_addr = 5'd9;
        #1;
        tests++;
        if (bus.rs2_data !== 32'h0000007F) begin
            failures++;
            $display("FAIL load_writeback: got %h expected 0000007f", bus.rs2_data);
        end
    endtask

    task automatic test_x0();
        idle();
        bus.wb_rw = 1'b1; bus.wb_rd = 5'd0; bus.wb_g = 32'hDEAD; bus.wb_opcode = 7'h13;
        bus.rs1_addr = 5'd0;
        #1;
        tests++;
        if (bus.wb_we !== 1'b0) begin
            failures++;
            $display("FAIL x0_we: got %b expected 0", bus.wb_we);
        end
        tests++;
        if (bus.rs1_data !== 32'd0) begin
            failures++;
            $display("FAIL x0_same_cycle: got %h expected 00000000", bus.rs1_data);
        end
        step();
        bus.wb_rw = 1'b0; bus.wb_opcode = 7'h00;
        #1;
        tests++;
        if (bus.rs1_data !== 32'd0) begin
            failures++;
            $display("FAIL x0_next_cycle: got %h expected 00000000", bus.rs1_data);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.wb_rw = 1'b1; bus.wb_rd = 5'd7; bus.wb_g = 32'hA5A5; bus.wb_opcode = 7'h33;
        bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
        #1;
        tests++;
        if (bus.wb_we !== 1'b1) begin
            failures++;
            $display("FAIL bypass_we: got %b expected 1", bus.wb_we);
        end
        tests++;
        if (bus.rs1_data !== 32'hA5A5 || bus.rs2_data !== 32'hA5A5) begin
            failures++;
            $display("FAIL bypass_same_cycle: got %h/%h expected 0000a5a5/0000a5a5",
                     bus.rs1_data, bus.rs2_data);
        end
        step();
        bus.wb_rw = 1'b0; bus.wb_g = 32'h0; bus.wb_opcode = 7'h00;
        #1;
        tests++;
        if (bus.rs1_data !== 32'hA5A5 || bus.rs2_data !== 32'hA5A5) begin
            failures++;
            $display("FAIL bypass_stored: got %h/%h expected 0000a5a5/0000a5a5",
                     bus.rs1_data, bus.rs2_data);
        end
        bus.wb_rw = 1'b1; bus.wb_rd = 5'd8; bus.wb_g = 32'h5555;
        bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd8;
        #1;
        tests++;
        if (bus.rs1_data !== 32'hA5A5 || bus.rs2_data !== 32'h5555) begin
            failures++;
            $display("FAIL bypass_one_port: got %h/%h expected 0000a5a5/00005555",
                     bus.rs1_data, bus.rs2_data);
        end
        bus.wb_rw = 1'b0;
    endtask

    task automatic test_retire();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.wb_opcode = 7'h33; bus.wb_rw = 1'b1; bus.wb_rd = 5'd10;
        for (int i = 0; i < 10; i++) step();
        bus.wb_opcode = 7'h00; bus.wb_rw = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.wb_opcode = 7'h23;
        for (int i = 0; i < 2; i++) step();
        bus.wb_opcode = 7'h00;
        #1;
        tests++;
        if (bus.instret !== 64'd12) begin
            failures++;
            $display("FAIL retire_count: got %0d expected 12", bus.instret);
        end
    endtask

    task automatic test_wrap();
        idle();
        @(negedge clk);
        force dut.instret_q = '1;
        #1;
        tests++;
        if (bus.instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preload: got %h expected ffffffffffffffff", bus.instret);
        end
        release dut.instret_q;
        bus.wb_opcode = 7'h33;
        step();
        bus.wb_opcode = 7'h00;
        #1;
        tests++;
        if (bus.instret !== 64'd0) begin
            failures++;
            $display("FAIL wrap_zero: got %h expected 0000000000000000", bus.instret);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        reset    = 1'b1;
        idle();
        test_reset();
        test_write_reset();
        test_load_extract();
        test_x0();
        test_bypass();
        test_retire();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
